// File: rtl/bitty_fetch_unit.sv
// Instruction fetch/issue stage for the bitty core: owns the PC, reads words over a
// req/valid handshake and holds run for CORE_CYCLES per word. Define
// BITTY_FETCH_PREFETCH_EN to fetch the next word into a one-entry buffer during EXEC.
module bitty_fetch_unit #(
    parameter int unsigned        ADDR_W      = 8,
    parameter int unsigned        CORE_CYCLES = 3,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       instruction,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam int unsigned       CNT_W     = (CORE_CYCLES > 1) ? $clog2(CORE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CORE_CYCLES - 1);
    localparam logic [15:0]       HALT_WORD = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [15:0]       instr_q, instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req;
    logic [ADDR_W-1:0] addr;

`ifdef BITTY_FETCH_PREFETCH_EN
    logic              buf_valid_q, buf_valid_d;
    logic [15:0]       buf_q, buf_d;
`endif

    // Truncation to ADDR_W gives the modular wrap from the top address to zero.
    assign pc_inc = pc_q + ADDR_W'(1);

    // NOTE: every signal written below gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        addr    = pc_q;
`ifdef BITTY_FETCH_PREFETCH_EN
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                req = 1'b1;
                if (mem_valid) begin
                    instr_d = mem_rdata;
                    cnt_d   = '0;
                    state_d = (mem_rdata == HALT_WORD) ? S_HALT : S_EXEC;
                end
            end

            S_EXEC: begin
`ifdef BITTY_FETCH_PREFETCH_EN
                // Request for pc+1 stays up until the buffer holds its word.
                req  = !buf_valid_q;
                addr = pc_inc;
                if (req && mem_valid) begin
                    buf_valid_d = 1'b1;
                    buf_d       = mem_rdata;
                end
`endif
                if (cnt_q == CNT_LAST) begin
                    pc_d  = pc_inc;
                    cnt_d = '0;
`ifdef BITTY_FETCH_PREFETCH_EN
                    if (buf_valid_d) begin
                        instr_d     = buf_d;
                        buf_valid_d = 1'b0;
                        state_d     = (buf_d == HALT_WORD) ? S_HALT : S_EXEC;
                    end else begin
                        // The outstanding request carries over: FETCH drives the
                        // same address because pc now equals the prefetch address.
                        state_d = S_FETCH;
                    end
`else
                    state_d = S_FETCH;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_HALT: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = S_FETCH;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
`ifdef BITTY_FETCH_PREFETCH_EN
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
`ifdef BITTY_FETCH_PREFETCH_EN
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
`endif
        end
    end

    assign mem_req     = req;
    assign mem_addr    = addr;
    assign instruction = instr_q;
    assign run         = (state_q == S_EXEC);
    assign pc          = pc_q;
    assign halted      = (state_q == S_HALT);

    // A pending request must hold its address until memory accepts it.
    a_req_stable : assert property (
        @(posedge clk) disable iff (reset)
        (mem_req && !mem_valid) |=> (mem_req && $stable(mem_addr))
    );

    // The HALT word is never handed to the core.
    a_no_halt_exec : assert property (
        @(posedge clk) disable iff (reset)
        run |-> (instruction != HALT_WORD)
    );

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Directed bench for bitty_fetch_unit: table-driven first program plus hand-written
// sequences for wait states, reset abort, start filtering, PC wrap and prefetch timing.
module tb_bitty_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mem_req, mem_valid, run, halted;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_rdata, instruction;

    logic        start_w = 1'b0;
    logic        mem_req_w, run_w, halted_w, valid_w;
    logic [1:0]  mem_addr_w, pc_w;
    logic [15:0] rdata_w, instr_w;

    logic [15:0] mem   [256];
    logic [15:0] mem_w [4];

    int checks = 0;
    int errors = 0;

    // Memory responder with a programmable number of wait states.
    int          wait_states = 0;
    int          wcnt = 0;
    logic        resp_valid = 1'b0;
    logic [15:0] resp_data = '0;
    logic        auto_mem = 1'b1;
    logic        man_valid = 1'b0;
    logic [15:0] man_data = '0;

    assign mem_valid = auto_mem ? resp_valid : man_valid;
    assign mem_rdata = auto_mem ? resp_data  : man_data;
    assign valid_w   = mem_req_w;
    assign rdata_w   = mem_w[mem_addr_w];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset || !mem_req) begin
            wcnt       = 0;
            resp_valid = 1'b0;
        end else if (wcnt >= wait_states) begin
            resp_valid = 1'b1;
            resp_data  = mem[mem_addr];
            wcnt       = 0;
        end else begin
            resp_valid = 1'b0;
            wcnt++;
        end
    end

    bitty_fetch_unit #(.ADDR_W(8), .CORE_CYCLES(3), .RESET_PC(8'd0)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .instruction (instruction),
        .run         (run),
        .pc          (pc),
        .halted      (halted)
    );

    bitty_fetch_unit #(.ADDR_W(2), .CORE_CYCLES(3), .RESET_PC(2'd0)) u_narrow (
        .clk         (clk),
        .reset       (reset),
        .start       (start_w),
        .mem_req     (mem_req_w),
        .mem_addr    (mem_addr_w),
        .mem_rdata   (rdata_w),
        .mem_valid   (valid_w),
        .instruction (instr_w),
        .run         (run_w),
        .pc          (pc_w),
        .halted      (halted_w)
    );

    typedef struct {
        logic        start;
        logic        req;
        logic [7:0]  addr;
        logic        run;
        logic [7:0]  pc;
        logic [15:0] ins;
        logic        halt;
    } vec_t;

    vec_t t1 [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_halted(input string name);
        int n = 0;
        while (!halted && n < 60) begin
            tick();
            n++;
        end
        check(name, 32'(halted), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 4; i++) mem_w[i] = 16'h1001 + 16'(i);

        // Reset state, with start held high to show reset wins.
        start = 1'b1;
        tick();
        tick();
        check("rst_req",   32'(mem_req),     32'd0);
        check("rst_addr",  32'(mem_addr),    32'd0);
        check("rst_run",   32'(run),         32'd0);
        check("rst_pc",    32'(pc),          32'd0);
        check("rst_ins",   32'(instruction), 32'd0);
        check("rst_halt",  32'(halted),      32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        check("idle_req",  32'(mem_req),     32'd0);
        check("idle_run",  32'(run),         32'd0);

        // Program 1: one instruction then HALT, zero-wait memory.
        mem[0] = 16'h2A48;
        mem[1] = 16'h0000;
        t1[0] = '{1'b1, 1'b1, 8'd0, 1'b0, 8'd0, 16'h0000, 1'b0};
`ifdef BITTY_FETCH_PREFETCH_EN
        t1[1] = '{1'b0, 1'b1, 8'd1, 1'b1, 8'd0, 16'h2A48, 1'b0};
        t1[2] = '{1'b0, 1'b0, 8'd1, 1'b1, 8'd0, 16'h2A48, 1'b0};
        t1[3] = '{1'b0, 1'b0, 8'd1, 1'b1, 8'd0, 16'h2A48, 1'b0};
        t1[4] = '{1'b0, 1'b0, 8'd1, 1'b0, 8'd1, 16'h0000, 1'b1};
`else
        t1[1] = '{1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 16'h2A48, 1'b0};
        t1[2] = '{1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 16'h2A48, 1'b0};
        t1[3] = '{1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 16'h2A48, 1'b0};
        t1[4] = '{1'b0, 1'b1, 8'd1, 1'b0, 8'd1, 16'h2A48, 1'b0};
`endif
        t1[5] = '{1'b0, 1'b0, 8'd1, 1'b0, 8'd1, 16'h0000, 1'b1};
        t1[6] = '{1'b0, 1'b0, 8'd1, 1'b0, 8'd1, 16'h0000, 1'b1};
        for (int i = 0; i < 7; i++) begin
            start = t1[i].start;
            tick();
            start = 1'b0;
            check($sformatf("t1[%0d].req", i),  32'(mem_req),     32'(t1[i].req));
            check($sformatf("t1[%0d].addr", i), 32'(mem_addr),    32'(t1[i].addr));
            check($sformatf("t1[%0d].run", i),  32'(run),         32'(t1[i].run));
            check($sformatf("t1[%0d].pc", i),   32'(pc),          32'(t1[i].pc));
            check($sformatf("t1[%0d].ins", i),  32'(instruction), 32'(t1[i].ins));
            check($sformatf("t1[%0d].halt", i), 32'(halted),      32'(t1[i].halt));
        end

        // Four wait states; start pulses in FETCH and EXEC must be ignored.
        mem[0] = 16'h1234;
        wait_states = 4;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ws_s0_req",  32'(mem_req),  32'd1);
        check("ws_s0_addr", 32'(mem_addr), 32'd0);
        check("ws_s0_run",  32'(run),      32'd0);
        for (int k = 1; k < 5; k++) begin
            if (k == 2) start = 1'b1;
            tick();
            start = 1'b0;
            check($sformatf("ws_s%0d_req", k),  32'(mem_req),  32'd1);
            check($sformatf("ws_s%0d_addr", k), 32'(mem_addr), 32'd0);
            check($sformatf("ws_s%0d_run", k),  32'(run),      32'd0);
        end
        tick();
        check("ws_exec_run", 32'(run),         32'd1);
        check("ws_exec_ins", 32'(instruction), 32'h1234);
        check("ws_exec_pc",  32'(pc),          32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("exec_start_run1", 32'(run), 32'd1);
        tick();
        check("exec_start_run2", 32'(run), 32'd1);
        wait_halted("ws_halted");
        check("ws_halt_pc", 32'(pc), 32'd1);

        // start in HALT refetches from RESET_PC.
        wait_states = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_req",  32'(mem_req),  32'd1);
        check("restart_addr", 32'(mem_addr), 32'd0);
        check("restart_pc",   32'(pc),       32'd0);
        check("restart_halt", 32'(halted),   32'd0);
        wait_halted("restart_halted");

        // Reset during the second EXEC cycle of the word at pc 1.
        mem[0] = 16'h2A48;
        mem[1] = 16'h1111;
        mem[2] = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 20 && !(run && pc == 8'd1); n++) tick();
        tick();
        check("pre_rst_run", 32'(run), 32'd1);
        check("pre_rst_pc",  32'(pc),  32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_run",  32'(run),     32'd0);
        check("mid_rst_req",  32'(mem_req), 32'd0);
        check("mid_rst_halt", 32'(halted),  32'd0);
        check("mid_rst_pc",   32'(pc),      32'd0);
        tick();
        reset = 1'b0;

        // A late mem_valid while idle must be ignored; start is needed to resume.
        auto_mem  = 1'b0;
        man_valid = 1'b1;
        man_data  = 16'h7777;
        tick();
        tick();
        tick();
        check("late_run", 32'(run),         32'd0);
        check("late_req", 32'(mem_req),     32'd0);
        check("late_ins", 32'(instruction), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("resume_req",  32'(mem_req),  32'd1);
        check("resume_addr", 32'(mem_addr), 32'd0);
        tick();
        auto_mem  = 1'b1;
        man_valid = 1'b0;
        check("resume_run", 32'(run),         32'd1);
        check("resume_ins", 32'(instruction), 32'h7777);
        wait_halted("resume_halted");
        check("resume_halt_pc", 32'(pc), 32'd2);

        // Four non-zero words then HALT: run timing with and without prefetch.
        mem[0] = 16'hA001;
        mem[1] = 16'hB002;
        mem[2] = 16'hC003;
        mem[3] = 16'hD004;
        mem[4] = 16'h0000;
        start = 1'b1;
        for (int k = 0; k < 19; k++) begin
            logic       e_run, e_halt;
            logic [7:0] e_pc;
            tick();
            start = 1'b0;
            e_run  = 1'b0;
            e_halt = 1'b0;
            e_pc   = 8'd0;
            if (k > 0) begin
`ifdef BITTY_FETCH_PREFETCH_EN
                if (k <= 12) begin
                    e_run = 1'b1;
                    e_pc  = 8'((k - 1) / 3);
                end else begin
                    e_halt = 1'b1;
                    e_pc   = 8'd4;
                end
`else
                if ((k - 1) / 4 >= 4) begin
                    e_halt = 1'b1;
                    e_pc   = 8'd4;
                end else if ((k - 1) % 4 == 3) begin
                    e_pc = 8'((k - 1) / 4 + 1);
                end else begin
                    e_run = 1'b1;
                    e_pc  = 8'((k - 1) / 4);
                end
`endif
            end
            check($sformatf("seq%0d_run", k),  32'(run),    32'(e_run));
            check($sformatf("seq%0d_pc", k),   32'(pc),     32'(e_pc));
            check($sformatf("seq%0d_halt", k), 32'(halted), 32'(e_halt));
            if (e_run) check($sformatf("seq%0d_ins", k), 32'(instruction), 32'(mem[e_pc]));
        end

        // ADDR_W=2: after the word at address 3 executes, fetching wraps to 0.
        begin
            logic seen3 = 1'b0;
            logic wrap_ok = 1'b0;
            logic rerun = 1'b0;
            start_w = 1'b1;
            tick();
            start_w = 1'b0;
            for (int n = 0; n < 60 && !rerun; n++) begin
                if (run_w && pc_w == 2'd3) seen3 = 1'b1;
                if (seen3 && !wrap_ok && mem_req_w) begin
                    check("wrap_addr", 32'(mem_addr_w), 32'd0);
                    wrap_ok = 1'b1;
                end
                if (wrap_ok && run_w && pc_w == 2'd0) begin
                    check("wrap_ins", 32'(instr_w), 32'h1001);
                    rerun = 1'b1;
                end
                if (!rerun) tick();
            end
            check("wrap_seen",  32'(wrap_ok), 32'd1);
            check("wrap_rerun", 32'(rerun),   32'd1);
            check("wrap_nohalt", 32'(halted_w), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
